// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: 4-digit BCD up/down counter feeding a time-multiplexed 7-segment digit scanner.
// Define LZ_BLANK_EN to enable leading-zero blanking on the num output.
module bcd_scan_counter #(
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic        up_dn,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] bcd,
    output logic        carry,
    output logic [3:0]  num,
    output logic [3:0]  an
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    idx;
    logic          tick;
    logic          scan_adv;
    logic [15:0]   step_val;
    logic          step_wrap;
    logic          ripple;
    logic [15:0]   load_sat;
    logic [3:0]    sel_digit;
    logic          blank;
    logic [3:0]    digit_out;

    assign tick     = (tick_cnt == TICK_LAST);
    assign scan_adv = (scan_cnt == SCAN_LAST);

    // Per-digit ripple: a digit only moves while every lower digit wrapped (9->0 up, 0->9 down).
    always_comb begin
        step_val = bcd;
        ripple   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (ripple) begin
                if (up_dn) begin
                    if (bcd[4*i +: 4] == 4'd9) begin
                        step_val[4*i +: 4] = 4'd0;
                    end else begin
                        step_val[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
                        ripple = 1'b0;
                    end
                end else begin
                    if (bcd[4*i +: 4] == 4'd0) begin
                        step_val[4*i +: 4] = 4'd9;
                    end else begin
                        step_val[4*i +: 4] = bcd[4*i +: 4] - 4'd1;
                        ripple = 1'b0;
                    end
                end
            end
        end
        step_wrap = ripple;
    end

    always_comb begin
        load_sat = load_val;
        for (int i = 0; i < 4; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                load_sat[4*i +: 4] = 4'd9;
            end
        end
    end

    assign sel_digit = bcd[{idx, 2'b00} +: 4];

`ifdef LZ_BLANK_EN
    // A digit is blank when it and everything above it is zero; digit 0 always shows.
    always_comb begin
        blank = 1'b0;
        case (idx)
            2'd1:    blank = (bcd[15:4] == 12'd0);
            2'd2:    blank = (bcd[15:8] == 8'd0);
            2'd3:    blank = (bcd[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    assign digit_out = blank ? 4'hF : sel_digit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd      <= 16'h0000;
            carry    <= 1'b0;
            tick_cnt <= '0;
        end else begin
            carry <= 1'b0;
            if (clr) begin
                bcd      <= 16'h0000;
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
                if (load) begin
                    bcd <= load_sat;
                end else if (tick && en) begin
                    bcd   <= step_val;
                    carry <= step_wrap;
                end
            end
        end
    end

    // an and num come from the same idx/bcd snapshot so digit changes never overlap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
            an       <= 4'b1110;
            num      <= 4'h0;
        end else begin
            scan_cnt <= scan_adv ? '0 : scan_cnt + SW'(1);
            if (scan_adv) begin
                idx <= idx + 2'd1;
            end
            an  <= ~(4'b0001 << idx);
            num <= digit_out;
        end
    end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb_bcd_scan_counter: table-driven vectors plus a cycle scoreboard against a decimal-integer model.
// Honours LZ_BLANK_EN in the same way as the design.
module tb_bcd_scan_counter;

    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic        up_dn;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] bcd;
    logic        carry;
    logic [3:0]  num;
    logic [3:0]  an;

    bcd_scan_counter #(
        .TICK_DIV(TICK_DIV),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clr     (clr),
        .up_dn   (up_dn),
        .load    (load),
        .load_val(load_val),
        .bcd     (bcd),
        .carry   (carry),
        .num     (num),
        .an      (an)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] bcd;
        logic        carry;
        logic [3:0]  an;
        logic [3:0]  num;
    } exp_t;

    typedef struct {
        logic        rn;
        logic        en;
        logic        clr;
        logic        up;
        logic        ld;
        logic [15:0] lv;
        int          cycles;
        logic [15:0] expBcd;
        logic        expCarry;
    } vec_t;

    exp_t sbQueue[$];
    vec_t vecs[12];

    int checkCount = 0;
    int passCount  = 0;

    // Model state kept as a plain decimal integer
    int         mBcd   = 0;
    int         mTick  = 0;
    int         mScan  = 0;
    int         mIdx   = 0;
    logic       mCarry = 1'b0;
    logic [3:0] mAn    = 4'b1110;
    logic [3:0] mNum   = 4'h0;

    function automatic int pow10(input int i);
        int p = 1;
        repeat (i) p = p * 10;
        return p;
    endfunction

    function automatic logic [15:0] toBcd(input int v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic int satLoad(input logic [15:0] lv);
        int v = 0;
        int n;
        for (int i = 0; i < 4; i++) begin
            n = int'(lv[4*i +: 4]);
            if (n > 9) n = 9;
            v = v + n * pow10(i);
        end
        return v;
    endfunction

    function automatic logic [3:0] modelDigit(input int v, input int i);
        logic [3:0] d;
        d = 4'((v / pow10(i)) % 10);
`ifdef LZ_BLANK_EN
        if (i > 0 && v < pow10(i)) d = 4'hF;
`endif
        return d;
    endfunction

    task automatic checkValue(input string name, input logic [15:0] act, input logic [15:0] req);
        checkCount++;
        if (act === req) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    endtask

    task automatic checkOutput();
        exp_t ex;
        if (sbQueue.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL scoreboard_empty: got 0 entries, expected 1 at %0t", $time);
            return;
        end
        ex = sbQueue.pop_front();
        checkValue("sb_bcd",   bcd,            ex.bcd);
        checkValue("sb_carry", {15'h0, carry}, {15'h0, ex.carry});
        checkValue("sb_an",    {12'h0, an},    {12'h0, ex.an});
        checkValue("sb_num",   {12'h0, num},   {12'h0, ex.num});
    endtask

    // Drive one cycle, advance the model across the coming edge, then compare after it.
    task automatic applyStimulus(input logic r, input logic e, input logic c, input logic u,
                                 input logic l, input logic [15:0] lv);
        logic tickNow;
        exp_t ex;
        @(negedge clk);
        rst_n = r; en = e; clr = c; up_dn = u; load = l; load_val = lv;
        if (!r) begin
            mBcd = 0; mCarry = 1'b0; mTick = 0; mScan = 0; mIdx = 0;
            mAn = 4'b1110; mNum = 4'h0;
        end else begin
            tickNow = (mTick == TICK_DIV - 1);
            mAn  = ~(4'b0001 << mIdx);
            mNum = modelDigit(mBcd, mIdx);
            if (mScan == SCAN_DIV - 1) begin
                mScan = 0;
                mIdx  = (mIdx + 1) % 4;
            end else begin
                mScan++;
            end
            mCarry = 1'b0;
            if (c) begin
                mBcd  = 0;
                mTick = 0;
            end else begin
                mTick = tickNow ? 0 : mTick + 1;
                if (l) begin
                    mBcd = satLoad(lv);
                end else if (tickNow && e) begin
                    if (u) begin
                        if (mBcd == 9999) begin mBcd = 0; mCarry = 1'b1; end
                        else mBcd++;
                    end else begin
                        if (mBcd == 0) begin mBcd = 9999; mCarry = 1'b1; end
                        else mBcd--;
                    end
                end
            end
        end
        ex.bcd = toBcd(mBcd); ex.carry = mCarry; ex.an = mAn; ex.num = mNum;
        sbQueue.push_back(ex);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Reset, load lv, then watch 8 cycles of scanning against fixed an/num sequences.
    task automatic scanSequence(input string tag, input logic [15:0] lv, input logic [15:0] disp);
        logic [3:0] anSeq[8];
        int idxSeq[8];
        anSeq  = '{4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111, 4'b1110, 4'b1110};
        idxSeq = '{1, 1, 2, 2, 3, 3, 0, 0};
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, lv);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
            checkValue($sformatf("%s_an%0d", tag, k),  {12'h0, an},  {12'h0, anSeq[k]});
            checkValue($sformatf("%s_num%0d", tag, k), {12'h0, num},
                       {12'h0, disp[4*idxSeq[k] +: 4]});
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 16'h0000;

        //          rn    en    clr   up    ld    lv        cyc  expBcd    expCarry
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 2,  16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 48, 16'h0012, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0999, 1,  16'h0999, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 3,  16'h1000, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h9999, 1,  16'h9999, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 3,  16'h0000, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1,  16'h0000, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3,  16'h9999, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'hABCD, 1,  16'h9999, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 1,  16'h0000, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 20, 16'h0000, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 1,  16'h1234, 1'b0};

        for (int v = 0; v < 12; v++) begin
            for (int n = 0; n < vecs[v].cycles; n++) begin
                applyStimulus(vecs[v].rn, vecs[v].en, vecs[v].clr, vecs[v].up,
                              vecs[v].ld, vecs[v].lv);
            end
            checkValue($sformatf("vec%0d_bcd", v), bcd, vecs[v].expBcd);
            checkValue($sformatf("vec%0d_carry", v), {15'h0, carry}, {15'h0, vecs[v].expCarry});
        end

        for (int n = 0; n < 20; n++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        end
        checkValue("hold_1234", bcd, 16'h1234);

        scanSequence("scan1234", 16'h1234, 16'h1234);
`ifdef LZ_BLANK_EN
        scanSequence("scan0050", 16'h0050, 16'hFF50);
        scanSequence("scan0000", 16'h0000, 16'hFFF0);
`else
        scanSequence("scan0050", 16'h0050, 16'h0050);
        scanSequence("scan0000", 16'h0000, 16'h0000);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
